trs_char_rasterizer: RTL and testbench
======================================

// Module: trs_char_rasterizer
// PURPOSE
//  Consumer side of the 2 KB character-generator pROM (8-bit rows, 11-bit address
//  {code[7:0],row[2:0]}). Per scanline, fetches COLS character codes from video RAM,
//  looks up each glyph row in the font pROM and serialises it MSB-first into a
//  1-bit pixel stream for the TRS-80 Model 1 video path. Prefetches one cell ahead.
// PARAMETERS
//  COLS      64  characters per text row
//  ROM_LAT   2   pROM clk-to-dout latency in cycles (pipelined READ_MODE=1 => 2)
//  CELL_H    12  scanlines per text row; glyph rows >= 8 render blank
// PORTS
//  clk          in   1   system clock; all logic on rising edge
//  reset        in   1   synchronous, active-high
//  line_start   in   1   1-clk pulse: begin fetching a new scanline (aborts current)
//  text_row     in   4   text row index, sampled on line_start
//  glyph_row    in   4   scanline within cell (0..CELL_H-1), sampled on line_start
//  pix_en       in   1   pixel-clock enable; one pixel per asserted cycle
//  vram_addr    out  10  text_row*COLS + col
//  vram_rd      out  1   read strobe; vram_data valid exactly 1 clk later
//  vram_data    in   8   character code
//  rom_ad       out  11  {code, glyph_row[2:0]}
//  rom_ce       out  1   pROM clock enable
//  rom_oce      out  1   pROM output-register enable (tied to rom_ce)
//  rom_dout     in   8   glyph row, valid ROM_LAT clks after rom_ce
//  pixel        out  1   current pixel, 1 = lit
//  pixel_valid  out  1   pixel is part of the active line
//  line_done    out  1   1-clk pulse after the last pixel of column COLS-1
//  underflow    out  1   sticky: glyph not ready at its load slot
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, col=0, next_valid=0, shifter empty.
//  - Fetch FSM: IDLE -line_start-> VRD (vram_rd=1, 1 clk) -> VWAIT (latch code) ->
//    RRD (rom_ce=rom_oce=1, rom_ad driven, 1 clk) -> RWAIT (ROM_LAT-1 clks) ->
//    CAP (next_buf<=rom_dout, next_valid<=1); if col==COLS-1 -> IDLE, else col++ ->
//    HOLD until next_valid==0 -> VRD. Per-cell fetch = 3+ROM_LAT clks.
//  - glyph_row>=8: RRD/RWAIT skipped, CAP loads 8'h00; rom_ce stays 0.
//  - Shifter: loads next_buf (clears next_valid same clk) on first pix_en with
//    next_valid=1 after line_start, then every 8th pix_en. pixel=shift[7], shifts
//    left on each pix_en; pixel_valid=1 from first load until 8*COLS pixels output.
//  - Load slot with next_valid=0 once line running: load 8'h00, set underflow;
//    remaining pixel content for that line is unspecified, flag is the contract.
//  - line_done pulses the clk after pixel 8*COLS-1; pixel_valid and pixel drop to 0.
//  - line_start mid-line: abort, col=0, next_valid=0, shifter empty, pixel_valid=0,
//    underflow cleared, fetch restarts next clk. line_start wins over any
//    simultaneous CAP or load.
//  - reset mid-operation: synchronous return to reset state in one clk.
//  - No pix_en between loads: shifter holds; fetch FSM independent of pix_en.
// STRUCTURE
//  - trs_video_pkg: COLS, CELL_H, GLYPH_H=8, fetch-FSM state enum.
//  - Sub-module glyph_shifter: 8-bit load/shift register, 3-bit pixel counter,
//    cell counter, pixel_valid/line_done/underflow generation.
//  - Top holds fetch FSM, col counter, next_buf/next_valid handshake.
// TESTING
//  - Stub VRAM row 0 = 'A'(0x41) x64, ROM model ROM_LAT=2, glyph_row=3, pix_en every
//    clk -> 512 pixels equal ROM[{0x41,3}] MSB-first repeated; line_done once; no underflow.
//  - text_row=5 -> first vram_addr=320, last=383; vram_rd exactly 64 pulses.
//  - glyph_row=9 -> rom_ce never asserted; 512 pixels all 0; pixel_valid high 512 clks.
//  - ROM_LAT=8, pix_en every clk -> underflow set at cell 1 slot; next line_start clears it.
//  - line_start at pixel 100 -> pixel_valid drops next clk, vram_addr restarts at row base.
//  - reset asserted during RWAIT -> all outputs 0 next clk; fresh line_start runs clean.

Source files
------------

// File: rtl/trs_char_rasterizer_pkg.sv
// Shared constants and fetch-FSM encoding for the TRS-80 character rasterizer.
// COLS cells per scanline, GLYPH_H font rows per glyph, CELL_H scanlines per text row.
package trs_char_rasterizer_pkg;

    localparam int COLS    = 64;
    localparam int CELL_H  = 12;
    localparam int GLYPH_H = 8;
    localparam int COL_W   = $clog2(COLS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VRD,
        S_VWAIT,
        S_RRD,
        S_RWAIT,
        S_CAP,
        S_HOLD
    } fetch_state_e;

endpackage

// File: rtl/trs_char_rasterizer_if.sv
// Video RAM read port and font pROM port of the character rasterizer.
// master = rasterizer side, slave = memory side.
interface trs_char_rasterizer_if;

    logic [9:0]  vram_addr;
    logic        vram_rd;
    logic [7:0]  vram_data;
    logic [10:0] rom_ad;
    logic        rom_ce;
    logic        rom_oce;
    logic [7:0]  rom_dout;

    modport master (
        output vram_addr,
        output vram_rd,
        output rom_ad,
        output rom_ce,
        output rom_oce,
        input  vram_data,
        input  rom_dout
    );

    modport slave (
        input  vram_addr,
        input  vram_rd,
        input  rom_ad,
        input  rom_ce,
        input  rom_oce,
        output vram_data,
        output rom_dout
    );

endinterface

// File: rtl/trs_char_rasterizer_glyph_shifter.sv
// Glyph row serialiser: loads one prefetched row per cell, shifts MSB-first,
// and generates pixel_valid, line_done and the sticky underflow flag.
module trs_char_rasterizer_glyph_shifter
    import trs_char_rasterizer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       line_start,
    input  logic       pix_en,
    input  logic       next_valid,
    input  logic [7:0] next_buf,
    output logic       take,
    output logic       pixel,
    output logic       pixel_valid,
    output logic       line_done,
    output logic       underflow
);

    logic [7:0]       shift_q;
    logic [2:0]       bit_q;
    logic [COL_W-1:0] cell_q;
    logic             run_q;
    logic             armed_q;
    logic             done_q;
    logic             uf_q;

    logic first_load;
    logic slot;
    logic last_cell;

    always_comb begin
        first_load = pix_en && !run_q && armed_q && next_valid;
        slot       = pix_en && run_q && (bit_q == 3'd7);
        last_cell  = (cell_q == COL_W'(COLS - 1));
        // line_start discards any load that would otherwise happen this clk
        take       = !line_start &&
                     (first_load || (slot && !last_cell && next_valid));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            bit_q   <= '0;
            cell_q  <= '0;
            run_q   <= 1'b0;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
            uf_q    <= 1'b0;
        end else if (line_start) begin
            shift_q <= '0;
            bit_q   <= '0;
            cell_q  <= '0;
            run_q   <= 1'b0;
            armed_q <= 1'b1;
            done_q  <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (first_load) begin
                shift_q <= next_buf;
                bit_q   <= '0;
                cell_q  <= '0;
                run_q   <= 1'b1;
            end else if (pix_en && run_q) begin
                if (bit_q != 3'd7) begin
                    shift_q <= {shift_q[6:0], 1'b0};
                    bit_q   <= bit_q + 3'd1;
                end else if (last_cell) begin
                    shift_q <= '0;
                    bit_q   <= '0;
                    run_q   <= 1'b0;
                    armed_q <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    shift_q <= next_valid ? next_buf : 8'h00;
                    uf_q    <= uf_q | !next_valid;
                    bit_q   <= '0;
                    cell_q  <= cell_q + COL_W'(1);
                end
            end
        end
    end

    assign pixel       = shift_q[7];
    assign pixel_valid = run_q;
    assign line_done   = done_q;
    assign underflow   = uf_q;

endmodule

// File: rtl/trs_char_rasterizer.sv
// Character rasterizer top: per-cell VRAM/pROM fetch FSM with a one-cell
// prefetch buffer feeding the glyph shifter.
module trs_char_rasterizer #(
    parameter int ROM_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  line_start,
    input  logic [3:0]            text_row,
    input  logic [3:0]            glyph_row,
    input  logic                  pix_en,
    trs_char_rasterizer_if.master mem,
    output logic                  pixel,
    output logic                  pixel_valid,
    output logic                  line_done,
    output logic                  underflow
);

    import trs_char_rasterizer_pkg::*;

    localparam logic [3:0] WAIT_LAST = 4'(ROM_LAT - 2);

    fetch_state_e     state_q;
    fetch_state_e     state_d;
    logic [COL_W-1:0] col_q;
    logic [9:0]       base_q;
    logic [7:0]       code_q;
    logic [2:0]       grow_q;
    logic             blank_q;
    logic [3:0]       wcnt_q;
    logic [7:0]       next_buf_q;
    logic             next_valid_q;
    logic             take;
    logic             last_col;

    assign last_col = (col_q == COL_W'(COLS - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_VRD:   state_d = S_VWAIT;
            S_VWAIT: state_d = blank_q ? S_CAP : S_RRD;
            S_RRD:   state_d = (ROM_LAT > 1) ? S_RWAIT : S_CAP;
            S_RWAIT: if (wcnt_q == WAIT_LAST) state_d = S_CAP;
            S_CAP:   state_d = last_col ? S_IDLE : S_HOLD;
            S_HOLD:  if (!next_valid_q) state_d = S_VRD;
            default: state_d = S_IDLE;
        endcase
        if (line_start) state_d = S_VRD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            base_q       <= '0;
            code_q       <= '0;
            grow_q       <= '0;
            blank_q      <= 1'b0;
            wcnt_q       <= '0;
            next_buf_q   <= '0;
            next_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (line_start) begin
                col_q        <= '0;
                base_q       <= 10'(text_row) * 10'(COLS);
                grow_q       <= glyph_row[2:0];
                blank_q      <= (glyph_row >= 4'(GLYPH_H));
                wcnt_q       <= '0;
                next_valid_q <= 1'b0;
            end else begin
                if (state_q == S_VWAIT) code_q <= mem.vram_data;
                if (state_q == S_RRD) wcnt_q <= '0;
                else if (state_q == S_RWAIT) wcnt_q <= wcnt_q + 4'd1;
                if (state_q == S_CAP) begin
                    next_buf_q   <= blank_q ? 8'h00 : mem.rom_dout;
                    next_valid_q <= 1'b1;
                    if (!last_col) col_q <= col_q + COL_W'(1);
                end else if (take) begin
                    next_valid_q <= 1'b0;
                end
            end
        end
    end

    assign mem.vram_addr = base_q + 10'(col_q);
    assign mem.vram_rd   = (state_q == S_VRD);
    assign mem.rom_ce    = (state_q == S_RRD);
    assign mem.rom_oce   = (state_q == S_RRD);
    assign mem.rom_ad    = {code_q, grow_q};

    trs_char_rasterizer_glyph_shifter u_shifter (
        .clk         (clk),
        .reset       (reset),
        .line_start  (line_start),
        .pix_en      (pix_en),
        .next_valid  (next_valid_q),
        .next_buf    (next_buf_q),
        .take        (take),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .line_done   (line_done),
        .underflow   (underflow)
    );

endmodule

// File: tb/tb_trs_char_rasterizer.sv
// Randomized bench for trs_char_rasterizer: VRAM/pROM models and a
// scanline reference built from font[{vram[row*64+col], glyph_row}].
module tb_trs_char_rasterizer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       line_start = 1'b0;
    logic [3:0] text_row = '0;
    logic [3:0] glyph_row = '0;
    logic       pix_en = 1'b1;
    logic       pe_rand = 1'b0;

    logic px2, pv2, ld2, uf2;
    logic px8, pv8, ld8, uf8;

    logic [7:0] vram [1024];
    logic [7:0] rom  [2048];
    logic [7:0] p2   [2];
    logic [7:0] p8   [8];

    int n_chk = 0;
    int n_fail = 0;

    logic       pix_q  [$];
    logic [9:0] addr_q [$];
    int ce_cnt, oce_bad, pv_cyc, ld_cnt, uf8_at, pv8_cyc;

    trs_char_rasterizer_if m2 ();
    trs_char_rasterizer_if m8 ();

    trs_char_rasterizer #(.ROM_LAT(2)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .line_start  (line_start),
        .text_row    (text_row),
        .glyph_row   (glyph_row),
        .pix_en      (pix_en),
        .mem         (m2),
        .pixel       (px2),
        .pixel_valid (pv2),
        .line_done   (ld2),
        .underflow   (uf2)
    );

    trs_char_rasterizer #(.ROM_LAT(8)) u_dut8 (
        .clk         (clk),
        .reset       (reset),
        .line_start  (line_start),
        .text_row    (text_row),
        .glyph_row   (glyph_row),
        .pix_en      (pix_en),
        .mem         (m8),
        .pixel       (px8),
        .pixel_valid (pv8),
        .line_done   (ld8),
        .underflow   (uf8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m2.vram_rd) m2.vram_data <= vram[m2.vram_addr];
        if (m8.vram_rd) m8.vram_data <= vram[m8.vram_addr];
        if (m2.rom_ce) p2[0] <= rom[m2.rom_ad];
        p2[1] <= p2[0];
        if (m8.rom_ce) p8[0] <= rom[m8.rom_ad];
        for (int i = 1; i < 8; i++) p8[i] <= p8[i-1];
    end
    assign m2.rom_dout = p2[1];
    assign m8.rom_dout = p8[7];

    always @(negedge clk) begin
        if (m2.vram_rd) addr_q.push_back(m2.vram_addr);
        if (m2.rom_ce) ce_cnt++;
        if (m2.rom_oce !== m2.rom_ce) oce_bad++;
        if (pv2) pv_cyc++;
        if (pv2 && pix_en) pix_q.push_back(px2);
        if (ld2) ld_cnt++;
        if (uf8 && uf8_at < 0) uf8_at = pv8_cyc;
        if (pv8) pv8_cyc++;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1 pix_en = pe_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_row(input int tr, input int c,
                                           input int gr);
        logic [10:0] a;
        if (gr >= 8) return 8'h00;
        a = {vram[tr*64 + c], 3'(gr)};
        return rom[a];
    endfunction

    task automatic clr_mon();
        pix_q.delete();
        addr_q.delete();
        ce_cnt = 0;
        oce_bad = 0;
        pv_cyc = 0;
        ld_cnt = 0;
        uf8_at = -1;
        pv8_cyc = 0;
    endtask

    task automatic start_line(input int tr, input int gr);
        @(posedge clk);
        #1;
        line_start = 1'b1;
        text_row = 4'(tr);
        glyph_row = 4'(gr);
        @(posedge clk);
        #1;
        line_start = 1'b0;
        clr_mon();
    endtask

    task automatic wait_done();
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            if (ld_cnt > 0) break;
        end
        check("line_done_seen", 32'(ld_cnt > 0), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_line(input int tr, input int gr);
        int err = 0;
        int n;
        logic [7:0] row;
        n = pix_q.size();
        check("pix_count", n, 512);
        for (int k = 0; k < 512 && k < n; k++) begin
            row = exp_row(tr, k / 8, gr);
            if (pix_q[k] !== row[7 - (k % 8)]) err++;
        end
        check("pix_data", err, 0);
        check("line_done_cnt", ld_cnt, 1);
        check("vram_rd_cnt", addr_q.size(), 64);
        if (addr_q.size() > 0) begin
            check("addr_first", 32'(addr_q[0]), tr * 64);
            check("addr_last", 32'(addr_q[addr_q.size()-1]), tr * 64 + 63);
        end
        check("rom_ce_cnt", ce_cnt, (gr < 8) ? 64 : 0);
        check("oce_tie", oce_bad, 0);
        check("underflow", 32'(uf2), 0);
        check("pv_end", 32'(pv2), 0);
        check("pixel_end", 32'(px2), 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_vram_rd"}, 32'(m2.vram_rd), 0);
        check({tag, "_vram_addr"}, 32'(m2.vram_addr), 0);
        check({tag, "_rom_ce"}, 32'(m2.rom_ce), 0);
        check({tag, "_rom_oce"}, 32'(m2.rom_oce), 0);
        check({tag, "_rom_ad"}, 32'(m2.rom_ad), 0);
        check({tag, "_pixel"}, 32'(px2), 0);
        check({tag, "_pv"}, 32'(pv2), 0);
        check({tag, "_ld"}, 32'(ld2), 0);
        check({tag, "_uf"}, 32'(uf2), 0);
    endtask

    initial begin
        int tr;
        int gr;
        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 1024; i++) vram[i] = 8'($urandom);
        for (int i = 0; i < 64; i++) vram[i] = 8'h41;
        rom[11'h20B] = 8'($urandom_range(1, 254));
        clr_mon();

        repeat (4) @(posedge clk);
        @(negedge clk);
        check_idle("rst");
        @(posedge clk);
        #1 reset = 1'b0;

        // row 0 of 'A', glyph row 3; the slow-ROM instance must underflow
        start_line(0, 3);
        wait_done();
        check_line(0, 3);
        check("pv_cycles", pv_cyc, 512);
        check("uf8_slot", uf8_at, 8);
        check("uf8_set", 32'(uf8), 1);

        gr = $urandom_range(0, 7);
        start_line(5, gr);
        @(negedge clk);
        check("uf8_clr", 32'(uf8), 0);
        wait_done();
        check_line(5, gr);

        start_line(2, 9);
        wait_done();
        check_line(2, 9);
        check("pv_cycles_blank", pv_cyc, 512);

        pe_rand = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tr = $urandom_range(0, 15);
            gr = $urandom_range(0, 11);
            start_line(tr, gr);
            wait_done();
            check_line(tr, gr);
        end
        pe_rand = 1'b0;

        // abort mid-line at pixel 100
        start_line(7, 4);
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk);
            if (pv_cyc >= 100) break;
        end
        check("abort_reached", 32'(pv_cyc >= 100), 1);
        #1;
        line_start = 1'b1;
        text_row = 4'd3;
        glyph_row = 4'd1;
        @(posedge clk);
        #1;
        line_start = 1'b0;
        clr_mon();
        @(negedge clk);
        check("abort_pv", 32'(pv2), 0);
        wait_done();
        check_line(3, 1);

        // reset while the pROM read is in flight
        start_line(1, 2);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (m2.rom_ce) break;
        end
        check("rrd_seen", 32'(m2.rom_ce), 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("rwait_rst");
        @(posedge clk);
        #1 reset = 1'b0;
        start_line(4, 6);
        wait_done();
        check_line(4, 6);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
